uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Byte-wide UART: one 8N1 transmitter and one 8N1 receiver sharing a parameterised baud divider.
- Sits behind the CPU's memory-mapped I/O controller. The controller writes the CONTROL/DATA registers and polls the STATUS registers; the serial pins go to the board.
- Frame format: idle high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.

Parameters:
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. DIV = CLK_FREQ/BAUD, integer-truncated. DIV must be ≥ 4 and is checked at elaboration.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- TX_CONTROL  in  8  bit0 SEND; bits 7:1 ignored.
- TX_DATA  in  8  byte to transmit; captured at start.
- TX_STATUS  out  8  bit0 BUSY, bit1 DONE; bits 7:2 read 0.
- TX  out  1  serial line out.
- RX  in  1  serial line in, asynchronous.
- RX_CONTROL  in  8  bit0 ENABLE, bit1 ACK; bits 7:2 ignored.
- RX_STATUS  out  8  bit0 READY, bit1 BUSY, bit2 FRAME_ERR, bit3 OVERRUN; bits 7:4 read 0.
- RX_DATA  out  8  last received byte.

Behaviour:

Interface rules
- One clock, CLK. Reset is asynchronous and active-high on RST.
- While RST is high: TX=1, TX_STATUS=0, RX_STATUS=0, RX_DATA=0, both state machines idle, all counters 0. Assertion mid-frame aborts the frame immediately; the line returns high.
- All outputs are registered.

Baud timing
- Each half has its own 0..DIV-1 counter, restarted when its frame starts. There is no free-running phase, so frames are jitter-free.
- Every bit lasts exactly DIV clocks.

TX (states IDLE, START, DATA, STOP)
- A 0->1 transition of TX_CONTROL[0] (edge-detected against a registered copy) while in IDLE starts a frame:
  - TX_DATA is latched into a shift register.
  - BUSY=1, DONE=0.
  - TX goes 0 on the next clock edge (1 cycle latency).
- A SEND edge while BUSY is ignored; holding SEND high does not retransmit.
- Sequence: start bit DIV clocks, then data bits 0..7 for DIV clocks each, then stop bit 1 for DIV clocks. Total frame is 10·DIV clocks.
- At the end of the stop bit: return to IDLE, BUSY=0, DONE=1.
- DONE stays set until the next frame starts.

RX (states IDLE, START, DATA, STOP, WAIT_HIGH)
- RX passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value.
- IDLE: when ENABLE=1 and a 1->0 transition is seen, go to START and set BUSY=1. With ENABLE=0 the receiver stays in IDLE.
- START: after DIV/2 clocks (integer) re-sample.
  - Sample 1: false start; return to IDLE, BUSY=0.
  - Sample 0: go to DATA.
- DATA: sample every DIV clocks (mid-bit), 8 samples shifted in LSB first.
- STOP: sample after a further DIV clocks.
  - RX_DATA is loaded with the byte; READY=1; FRAME_ERR = inverse of the stop sample.
  - If READY was already 1: OVERRUN=1 and the new byte overwrites RX_DATA.
  - If the stop sample is 1: go to IDLE, BUSY=0.
  - If the stop sample is 0: go to WAIT_HIGH, which holds until the line is 1, then IDLE, BUSY=0.
- ACK: a 0->1 transition of RX_CONTROL[1] clears READY and OVERRUN. FRAME_ERR is cleared by ACK and rewritten at every stop sample.
- If ACK and a byte completion occur in the same cycle, the completion wins: READY=1, and OVERRUN is set only if READY was 1 before that cycle.
- Clearing ENABLE mid-frame does not abort the frame; it only blocks new start detection.

Test Plan:
- Reset: apply RST mid-TX-frame with CLK_FREQ=16, BAUD=1 (DIV=16) -> TX=1 and all STATUS=0 immediately; no further TX transitions after release.
- TX 0xA5, DIV=16: pulse SEND -> TX goes low 1 clock after the edge. Bit sequence 0,1,0,1,0,0,1,0,1,1 at 16 clocks each. BUSY for 160 clocks, then DONE=1. Holding SEND high yields a single frame only.
- Loopback with TX tied to RX, ENABLE=1, send 0x3C -> READY=1, RX_DATA=0x3C, FRAME_ERR=0. ACK edge -> READY=0.
- Overrun: receive 0x11 then 0x22 without ACK -> RX_DATA=0x22, READY=1, OVERRUN=1. ACK clears both.
- Glitch: RX low for 5 clocks (< DIV/2=8) -> false start, BUSY returns 0, READY stays 0.
- Framing: drive 0x55 with stop bit 0, line held low 40 clocks then high -> READY=1, FRAME_ERR=1. No new start is detected until the line goes high, and the next good byte is received correctly.

Source files
------------

// File: rtl/uart_core.sv
// uart_core: byte-wide 8N1 UART. It has one transmitter and one receiver.
// Each half has its own baud counter, restarted at the start of its frame.
//
// Ports:
//   CLK        system clock; all logic runs on the rising edge
//   RST        asynchronous, active-high reset
//   TX_CONTROL bit0 SEND (rising edge starts a frame)
//   TX_DATA    byte to send, latched when the frame starts
//   TX_STATUS  bit0 BUSY, bit1 DONE
//   TX         serial output, idles high
//   RX         serial input, asynchronous to CLK
//   RX_CONTROL bit0 ENABLE, bit1 ACK (rising edge clears the flags)
//   RX_STATUS  bit0 READY, bit1 BUSY, bit2 FRAME_ERR, bit3 OVERRUN
//   RX_DATA    last byte received

module uart_core #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_CONTROL,
  input  logic [7:0] TX_DATA,
  output logic [7:0] TX_STATUS,
  output logic       TX,
  input  logic       RX,
  input  logic [7:0] RX_CONTROL,
  output logic [7:0] RX_STATUS,
  output logic [7:0] RX_DATA
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);

  generate
    if (DIV < 4) begin : g_div_chk
      $error("uart_core: CLK_FREQ/BAUD must be >= 4");
    end
  endgenerate

  logic w_unused;
  assign w_unused = ^{TX_CONTROL[7:1], RX_CONTROL[7:2]};

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

  tx_state_t       r_tx_state, w_tx_state_n;
  logic [CW-1:0]   r_tx_cnt, w_tx_cnt_n;
  logic [2:0]      r_tx_bit, w_tx_bit_n;
  logic [7:0]      r_tx_shift, w_tx_shift_n;
  logic            r_tx, w_tx_n;
  logic            r_tx_busy, w_tx_busy_n;
  logic            r_tx_done, w_tx_done_n;
  logic            r_send_q;
  logic            w_send_edge;
  logic            w_tx_wrap;

  assign w_send_edge = TX_CONTROL[0] & ~r_send_q;
  assign w_tx_wrap   = (r_tx_cnt == C_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_send_q   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx       <= w_tx_n;
      r_tx_busy  <= w_tx_busy_n;
      r_tx_done  <= w_tx_done_n;
      r_send_q   <= TX_CONTROL[0];
    end
  end

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_n       = r_tx;
    w_tx_busy_n  = r_tx_busy;
    w_tx_done_n  = r_tx_done;
    unique case (r_tx_state)
      T_IDLE: begin
        if (w_send_edge) begin
          w_tx_state_n = T_START;
          w_tx_cnt_n   = '0;
          w_tx_shift_n = TX_DATA;
          w_tx_n       = 1'b0;
          w_tx_busy_n  = 1'b1;
          w_tx_done_n  = 1'b0;
        end
      end
      T_START: begin
        if (w_tx_wrap) begin
          w_tx_state_n = T_DATA;
          w_tx_cnt_n   = '0;
          w_tx_bit_n   = '0;
          w_tx_n       = r_tx_shift[0];
        end else begin
          w_tx_cnt_n = r_tx_cnt + 1'b1;
        end
      end
      T_DATA: begin
        if (w_tx_wrap) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = T_STOP;
            w_tx_n       = 1'b1;
          end else begin
            // Shift first so bit[0] always holds the bit on the line.
            w_tx_bit_n   = r_tx_bit + 3'd1;
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
            w_tx_n       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + 1'b1;
        end
      end
      T_STOP: begin
        if (w_tx_wrap) begin
          w_tx_state_n = T_IDLE;
          w_tx_cnt_n   = '0;
          w_tx_busy_n  = 1'b0;
          w_tx_done_n  = 1'b1;
        end else begin
          w_tx_cnt_n = r_tx_cnt + 1'b1;
        end
      end
      default: begin
        w_tx_state_n = T_IDLE;
      end
    endcase
  end

  assign TX        = r_tx;
  assign TX_STATUS = {6'b0, r_tx_done, r_tx_busy};

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT
  } rx_state_t;

  rx_state_t       r_rx_state, w_rx_state_n;
  logic [CW-1:0]   r_rx_cnt, w_rx_cnt_n;
  logic [2:0]      r_rx_bit, w_rx_bit_n;
  logic [7:0]      r_rx_shift, w_rx_shift_n;
  logic [7:0]      r_rx_data, w_rx_data_n;
  logic            r_rx_ready, w_rx_ready_n;
  logic            r_rx_busy, w_rx_busy_n;
  logic            r_rx_ferr, w_rx_ferr_n;
  logic            r_rx_ovr, w_rx_ovr_n;
  logic            r_rx_s1, r_rx_s2, r_rx_prev;
  logic            r_ack_q;
  logic            w_fall;
  logic            w_ack_edge;
  logic            w_rx_wrap;

  assign w_fall     = r_rx_prev & ~r_rx_s2;
  assign w_ack_edge = RX_CONTROL[1] & ~r_ack_q;
  assign w_rx_wrap  = (r_rx_cnt == C_LAST);

  // Synchroniser resets high so the idle line does not look like a start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_ack_q   <= 1'b0;
    end else begin
      r_rx_s1   <= RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_ack_q   <= RX_CONTROL[1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_ready <= 1'b0;
      r_rx_busy  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_data  <= w_rx_data_n;
      r_rx_ready <= w_rx_ready_n;
      r_rx_busy  <= w_rx_busy_n;
      r_rx_ferr  <= w_rx_ferr_n;
      r_rx_ovr   <= w_rx_ovr_n;
    end
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_data_n  = r_rx_data;
    w_rx_ready_n = r_rx_ready;
    w_rx_busy_n  = r_rx_busy;
    w_rx_ferr_n  = r_rx_ferr;
    w_rx_ovr_n   = r_rx_ovr;
    // ACK is applied first so a byte completing in the same cycle wins.
    if (w_ack_edge) begin
      w_rx_ready_n = 1'b0;
      w_rx_ovr_n   = 1'b0;
      w_rx_ferr_n  = 1'b0;
    end
    unique case (r_rx_state)
      R_IDLE: begin
        if (RX_CONTROL[0] && w_fall) begin
          w_rx_state_n = R_START;
          w_rx_cnt_n   = '0;
          w_rx_busy_n  = 1'b1;
        end
      end
      R_START: begin
        if (r_rx_cnt == C_HALF) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          if (r_rx_s2) begin
            w_rx_state_n = R_IDLE;
            w_rx_busy_n  = 1'b0;
          end else begin
            w_rx_state_n = R_DATA;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (w_rx_wrap) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_n = R_STOP;
          end else begin
            w_rx_bit_n = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (w_rx_wrap) begin
          w_rx_cnt_n   = '0;
          w_rx_data_n  = r_rx_shift;
          w_rx_ready_n = 1'b1;
          w_rx_ovr_n   = w_rx_ovr_n | r_rx_ready;
          w_rx_ferr_n  = ~r_rx_s2;
          if (r_rx_s2) begin
            w_rx_state_n = R_IDLE;
            w_rx_busy_n  = 1'b0;
          end else begin
            w_rx_state_n = R_WAIT;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + 1'b1;
        end
      end
      R_WAIT: begin
        // A broken frame leaves the line low; wait for it to rise
        // so the tail is not taken as a new start bit.
        if (r_rx_s2) begin
          w_rx_state_n = R_IDLE;
          w_rx_busy_n  = 1'b0;
        end
      end
      default: begin
        w_rx_state_n = R_IDLE;
      end
    endcase
  end

  assign RX_DATA   = r_rx_data;
  assign RX_STATUS = {4'b0, r_rx_ovr, r_rx_ferr, r_rx_busy, r_rx_ready};

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: checks uart_core at DIV=16 against a byte-level model.
// Covers the TX frame, loopback, overrun, glitch, framing and reset cases.

module tb_uart_core;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_ctrl, tx_data, tx_stat;
  logic [7:0] rx_ctrl, rx_stat, rx_data;
  logic       tx, rx_drv, loop, rx_line;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_data;
  logic       exp_ready, exp_ovr, exp_ferr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         stop_len;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs[5];

  assign rx_line = loop ? tx : rx_drv;

  uart_core #(.CLK_FREQ(16), .BAUD(1)) dut (
    .CLK       (clk),
    .RST       (rst),
    .TX_CONTROL(tx_ctrl),
    .TX_DATA   (tx_data),
    .TX_STATUS (tx_stat),
    .TX        (tx),
    .RX        (rx_line),
    .RX_CONTROL(rx_ctrl),
    .RX_STATUS (rx_stat),
    .RX_DATA   (rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_rx(input logic [7:0] d, input logic stop);
    exp_ovr   = exp_ovr | exp_ready;
    exp_ready = 1'b1;
    exp_data  = d;
    exp_ferr  = ~stop;
  endtask

  task automatic model_ack();
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
    exp_ferr  = 1'b0;
  endtask

  task automatic check_rx(input string name);
    check({name, "_data"}, rx_data, exp_data);
    check({name, "_stat"}, rx_stat,
          {4'b0, exp_ovr, exp_ferr, 1'b0, exp_ready});
  endtask

  task automatic ack();
    rx_ctrl = rx_ctrl | 8'h02;
    tick(1);
    rx_ctrl = rx_ctrl & 8'hFD;
    model_ack();
    tick(1);
  endtask

  // Sends one byte and checks each bit at mid-bit, plus BUSY/DONE timing.
  task automatic tx_frame(input logic [7:0] d, input bit hold);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    check("tx_idle_pre", tx, 1);
    tx_data = d;
    tx_ctrl = 8'h01;
    tick(1);
    check("tx_start_lat", tx, 0);
    check("tx_busy_set", tx_stat, 8'h01);
    tx_data = ~d;
    if (!hold) tx_ctrl = 8'h00;
    for (int c = 1; c < 10 * DIV; c++) begin
      if (!hold && c == 3 * DIV) tx_ctrl = 8'h01;
      if (!hold && c == 3 * DIV + 2) tx_ctrl = 8'h00;
      tick(1);
      if (c % DIV == DIV / 2)
        check($sformatf("tx_bit%0d", c / DIV), tx, fr[c / DIV]);
    end
    check("tx_busy_end", tx_stat, 8'h01);
    tick(1);
    check("tx_done", tx_stat, 8'h02);
    check("tx_idle_post", tx, 1);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop,
                          input int stop_len);
    rx_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(DIV);
    end
    rx_drv = stop;
    tick(stop_len);
    rx_drv = 1'b1;
    tick(DIV);
  endtask

  initial begin
    int lows;
    logic [7:0] d;

    vecs[0] = '{8'h00, 1'b1, DIV, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, DIV, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b1, DIV, 8'h81, 1'b1, 1'b0};
    vecs[3] = '{8'h6E, 1'b1, DIV, 8'h6E, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, DIV, 8'hC3, 1'b1, 1'b1};

    rst      = 1'b1;
    tx_ctrl  = 8'h00;
    tx_data  = 8'h00;
    rx_ctrl  = 8'h00;
    rx_drv   = 1'b1;
    loop     = 1'b0;
    exp_data = 8'h00;
    model_ack();
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_tx_stat", tx_stat, 8'h00);
    check("rst_rx_stat", rx_stat, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    tick(2);

    // 0xA5 with SEND held high: exactly one frame.
    tx_frame(8'hA5, 1'b1);
    lows = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      tick(1);
      if (tx == 1'b0) lows++;
    end
    check("tx_no_retx", lows, 0);
    check("tx_done_hold", tx_stat, 8'h02);
    tx_ctrl = 8'h00;
    tick(2);

    // Loopback.
    loop    = 1'b1;
    rx_ctrl = 8'h01;
    tick(2);
    tx_frame(8'h3C, 1'b0);
    model_rx(8'h3C, 1'b1);
    check_rx("loop");
    ack();
    check_rx("loop_ack");

    // Driven frames from the table.
    loop = 1'b0;
    tick(2);
    foreach (vecs[i]) begin
      rx_frame(vecs[i].data, vecs[i].stop, vecs[i].stop_len);
      model_rx(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_ready", i), rx_stat[0], vecs[i].exp_ready);
      check($sformatf("vec%0d_ferr", i), rx_stat[2], vecs[i].exp_ferr);
      ack();
      check_rx($sformatf("vec%0d_ack", i));
    end

    // Overrun.
    rx_frame(8'h11, 1'b1, DIV);
    model_rx(8'h11, 1'b1);
    check_rx("ovr_first");
    rx_frame(8'h22, 1'b1, DIV);
    model_rx(8'h22, 1'b1);
    check_rx("ovr_second");
    ack();
    check_rx("ovr_ack");

    // Glitch shorter than half a bit.
    rx_drv = 1'b0;
    tick(5);
    rx_drv = 1'b1;
    check("glitch_busy", rx_stat[1], 1);
    tick(20);
    check("glitch_idle", rx_stat, 8'h00);

    // Framing error: stop bit low, line held low for 40 clocks.
    rx_drv = 1'b0;
    tick(DIV);
    d = 8'h55;
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(DIV);
    end
    rx_drv = 1'b0;
    tick(40);
    model_rx(8'h55, 1'b0);
    check("frm_wait_stat", rx_stat, 8'h07);
    check("frm_data", rx_data, 8'h55);
    rx_drv = 1'b1;
    tick(4);
    check_rx("frm_high");
    ack();
    rx_frame(8'hA6, 1'b1, DIV);
    model_rx(8'hA6, 1'b1);
    check_rx("frm_next");
    ack();

    // Receiver disabled: no start is taken.
    rx_ctrl = 8'h00;
    rx_frame(8'h99, 1'b1, DIV);
    check_rx("rx_disabled");
    rx_ctrl = 8'h01;

    // Random loopback against the model, with random ACKs.
    loop = 1'b1;
    tick(2);
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom_range(0, 255));
      tx_frame(d, 1'b0);
      model_rx(d, 1'b1);
      check_rx($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) ack();
    end

    // Reset mid-frame.
    tx_data = 8'h0F;
    tx_ctrl = 8'h01;
    tick(1);
    tx_ctrl = 8'h00;
    tick(40);
    #2 rst = 1'b1;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_tx_stat", tx_stat, 8'h00);
    check("rstmid_rx_stat", rx_stat, 8'h00);
    check("rstmid_rx_data", rx_data, 8'h00);
    tick(3);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 12 * DIV; c++) begin
      tick(1);
      if (tx == 1'b0) lows++;
    end
    check("rstmid_no_tx", lows, 0);
    check("rstmid_tx_stat2", tx_stat, 8'h00);
    check("rstmid_rx_stat2", rx_stat, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
